// File: rtl/neuro_nav_pkg.sv
// Shared types for the neuromorphic nav/SLAM peripheral: direction encoding,
// channel index type and the spike scheduler FSM states.
package neuro_nav_pkg;

  localparam int NUM_DIR = 4;

  // Spike channel index doubles as heading direction.
  typedef enum logic [1:0] {
    DIR_EAST  = 2'd0,
    DIR_NORTH = 2'd1,
    DIR_WEST  = 2'd2,
    DIR_SOUTH = 2'd3
  } dir_e;

  typedef logic [$clog2(NUM_DIR)-1:0] ch_idx_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } sched_state_e;

  // Successor of idx modulo n (idx assumed < n).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/spike_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of req found
// when searching upward from start (inclusive), wrapping modulo NUM_CH.
module spike_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   start,
  output logic [CH_W-1:0]   grant,
  output logic              any_req
);

  logic [2*NUM_CH-1:0] req2;
  logic [2*NUM_CH-1:0] rot;

  // Doubling the mask turns the wrap-around search into a plain shift.
  assign req2 = {req, req};
  assign rot  = req2 >> start;

  // Lowest set bit of the rotated mask, mapped back to an absolute channel.
  always_comb begin
    int s;
    grant   = '0;
    any_req = 1'b0;
    s       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_req && rot[i]) begin
        any_req = 1'b1;
        s       = int'(start) + i;
        if (s >= NUM_CH) s = s - NUM_CH;
        grant   = CH_W'(s);
      end
    end
  end

endmodule

// File: rtl/spike_event_scheduler.sv
// Spike event scheduler: captures rising edges on NUM_CH spike channels into
// saturating pending counters and serializes them round-robin onto a
// valid/ready event port, one event per handshake.
// Optional refractory filtering: define SPIKE_SCHED_REFRACTORY_EN.
module spike_event_scheduler
  import neuro_nav_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 3,
  parameter int REFRACT_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [NUM_CH-1:0]         spike_in,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [$clog2(NUM_CH)-1:0] ev_ch,
  output logic                      pending_any,
  output logic [NUM_CH-1:0]         overflow,
  input  logic [NUM_CH-1:0]         ovf_clr,
  input  logic [REFRACT_W-1:0]      refract_period
);

  localparam int              CH_W    = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [NUM_CH-1:0]            prev, rise, cap, dec;
  logic [NUM_CH-1:0]            cnt_nz, post_nz, sat_set, refr_busy;
  logic                         hs;
  sched_state_e                 state;
  logic [CH_W-1:0]              last_grant;
  logic [NUM_CH-1:0]            pick_req;
  logic [CH_W-1:0]              pick_start, pick_grant;
  logic                         pick_any;

  assign rise = spike_in & ~prev;
  assign hs   = ev_valid & ev_ready;
  assign cap  = rise & {NUM_CH{enable}} & ~refr_busy;

  // Edge history follows spike_in unconditionally so enabling capture while a
  // spike is already high never looks like a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= spike_in;
  end

`ifdef SPIKE_SCHED_REFRACTORY_EN
  logic [NUM_CH-1:0][REFRACT_W-1:0] refr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_refr_busy
    assign refr_busy[g] = |refr[g];
  end

  // Per-channel refractory timer: armed by a capture, counts down to zero,
  // and blocks captures while nonzero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refr <= '0;
    end else if (flush) begin
      refr <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap[i])            refr[i] <= refract_period;
        else if (refr_busy[i]) refr[i] <= refr[i] - REFRACT_W'(1);
      end
    end
  end
`else
  logic unused_refract;
  assign refr_busy      = '0;
  assign unused_refract = ^refract_period;
`endif

  // Per-channel counter next-state: simultaneous capture and delivery cancel;
  // a capture at full scale holds the count and raises the sticky flag.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign dec[g]     = hs && (ev_ch == CH_W'(g));
    assign cnt_nz[g]  = |cnt[g];
    assign post_nz[g] = cnt_nz[g] && !(dec[g] && (cnt[g] == CNT_W'(1)));
    assign sat_set[g] = cap[g] && !dec[g] && (cnt[g] == CNT_MAX);
    assign cnt_nxt[g] = (cap[g] && !dec[g]) ? ((cnt[g] == CNT_MAX) ? cnt[g] : cnt[g] + CNT_W'(1)) :
                        (dec[g] && !cap[g]) ? cnt[g] - CNT_W'(1) :
                                              cnt[g];
  end

  // Pending counters; flush discards everything including a same-cycle capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (flush) cnt <= '0;
    else            cnt <= cnt_nxt;
  end

  // Sticky saturation flags: a new set beats a same-cycle clear; flush leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      overflow <= '0;
    else if (!flush) overflow <= sat_set | (overflow & ~ovf_clr);
  end

  assign pending_any = |cnt_nz;

  // One picker serves both the idle pick (registered counts, after last_grant)
  // and the back-to-back re-pick (counts with this handshake removed, after ev_ch).
  assign pick_req   = (state == ST_OFFER) ? post_nz : cnt_nz;
  assign pick_start = (state == ST_OFFER) ? CH_W'(wrap_inc(int'(ev_ch), NUM_CH))
                                          : CH_W'(wrap_inc(int'(last_grant), NUM_CH));

  spike_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req     (pick_req),
    .start   (pick_start),
    .grant   (pick_grant),
    .any_req (pick_any)
  );

  // Offer FSM: the offer is frozen until accepted, then immediately replaced
  // by the next round-robin pick so a busy integrator sees one event per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ev_valid   <= 1'b0;
      ev_ch      <= '0;
      last_grant <= LAST_CH;
    end else if (flush) begin
      state      <= ST_IDLE;
      ev_valid   <= 1'b0;
      last_grant <= LAST_CH;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            ev_ch    <= pick_grant;
            ev_valid <= 1'b1;
            state    <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (hs) begin
            last_grant <= ev_ch;
            if (pick_any) begin
              ev_ch <= pick_grant;
            end else begin
              ev_valid <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          ev_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Directed bench for spike_event_scheduler with hand-computed expectations.
module tb_spike_event_scheduler;
  import neuro_nav_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 3;
  localparam int REFRACT_W = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 enable;
  logic                 flush;
  logic [NUM_CH-1:0]    spike_in;
  logic                 ev_valid;
  logic                 ev_ready;
  logic [1:0]           ev_ch;
  logic                 pending_any;
  logic [NUM_CH-1:0]    overflow;
  logic [NUM_CH-1:0]    ovf_clr;
  logic [REFRACT_W-1:0] refract_period;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ev;
  ch_idx_t west;

  always #5 clk = ~clk;

  spike_event_scheduler #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .REFRACT_W (REFRACT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .flush          (flush),
    .spike_in       (spike_in),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_ch          (ev_ch),
    .pending_any    (pending_any),
    .overflow       (overflow),
    .ovf_clr        (ovf_clr),
    .refract_period (refract_period)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    west           = DIR_WEST;
    rst_n          = 1'b0;
    enable         = 1'b1;
    flush          = 1'b0;
    spike_in       = '0;
    ev_ready       = 1'b1;
    ovf_clr        = '0;
    refract_period = '0;
    step(); step();
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_ch", 32'(ev_ch), 0);
    chk("rst_pend", 32'(pending_any), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    step();

    // Single spike on north: count after 1 edge, offer after 2, one cycle wide.
    spike_in = 4'b0010; step();
    chk("t1_pend", 32'(pending_any), 1);
    chk("t1_nooffer", 32'(ev_valid), 0);
    spike_in = '0; step();
    chk("t1_valid", 32'(ev_valid), 1);
    chk("t1_ch", 32'(ev_ch), 1);
    step();
    chk("t1_drop", 32'(ev_valid), 0);
    chk("t1_empty", 32'(pending_any), 0);

    // All four at once: served 0,1,2,3 back to back.
    flush = 1'b1; step(); flush = 1'b0;
    spike_in = 4'hF; step();
    spike_in = '0; step();
    chk("t2_ch0", {31'(ev_ch), ev_valid}, {31'd0, 1'b1});
    step(); chk("t2_ch1", {31'(ev_ch), ev_valid}, {31'd1, 1'b1});
    step(); chk("t2_ch2", {31'(ev_ch), ev_valid}, {31'd2, 1'b1});
    step(); chk("t2_ch3", {31'(ev_ch), ev_valid}, {31'd3, 1'b1});
    step(); chk("t2_done", 32'(ev_valid), 0);

    // Nine rises on west with ready low: saturate at 7 and flag overflow.
    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      spike_in = 4'b0100; step();
      spike_in = '0;      step();
    end
    chk("t3_ovf", 32'(overflow), 32'h4);
    chk("t3_ch", 32'(ev_ch), 32'(west));
    ev_ready = 1'b1;
    n_ev = 0;
    for (int c = 0; c < 12; c++) begin
      if (ev_valid && ev_ch == west) n_ev++;
      step();
    end
    chk("t3_events", 32'(n_ev), 7);
    chk("t3_empty", 32'(pending_any), 0);
    ev_ready = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    chk("t3_ovf_kept", 32'(overflow), 32'h4);
    ovf_clr = 4'b0100; step(); ovf_clr = '0;
    chk("t3_ovf_clr", 32'(overflow), 0);

    // Backpressure: offer of east must not move when south spikes.
    spike_in = 4'b0001; step();
    spike_in = '0; step();
    chk("t4_offer", {31'(ev_ch), ev_valid}, {31'd0, 1'b1});
    spike_in = 4'b1000; step();
    spike_in = '0;
    for (int c = 0; c < 4; c++) step();
    chk("t4_hold", {31'(ev_ch), ev_valid}, {31'd0, 1'b1});
    ev_ready = 1'b1; step();
    chk("t4_next", {31'(ev_ch), ev_valid}, {31'd3, 1'b1});
    step();
    chk("t4_done", 32'(ev_valid), 0);
    ev_ready = 1'b0;

    // Flush mid-drain.
    spike_in = 4'b0111; step();
    spike_in = '0; step();
    chk("t5_offer", {31'(ev_ch), ev_valid}, {31'd0, 1'b1});
    ev_ready = 1'b1; step();
    chk("t5_next", {31'(ev_ch), ev_valid}, {31'd1, 1'b1});
    flush = 1'b1; step(); flush = 1'b0;
    chk("t5_flush_valid", 32'(ev_valid), 0);
    chk("t5_flush_pend", 32'(pending_any), 0);
    step();
    chk("t5_stay_idle", 32'(ev_valid), 0);

    // Capture gated by enable; enabling over a held-high spike is not an edge.
    enable = 1'b0;
    spike_in = 4'b0010; step();
    spike_in = '0; step(); step();
    chk("t6_gated", {31'(pending_any), ev_valid}, 0);
    spike_in = 4'b0001; step();
    enable = 1'b1; step(); step();
    chk("t6_held", {31'(pending_any), ev_valid}, 0);
    spike_in = '0; step();

    // Rises on east at edges 0, 2, 4 with refract_period 3.
    ev_ready = 1'b0;
    refract_period = 4'd3;
    for (int i = 0; i < 3; i++) begin
      spike_in = 4'b0001; step();
      spike_in = '0;      step();
    end
    ev_ready = 1'b1;
    n_ev = 0;
    for (int c = 0; c < 8; c++) begin
      if (ev_valid) n_ev++;
      step();
    end
`ifdef SPIKE_SCHED_REFRACTORY_EN
    chk("t7_refract", 32'(n_ev), 2);
`else
    chk("t7_refract", 32'(n_ev), 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
